cbf_doa_scanner: RTL



---
 rtl/cbf_doa_scanner.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cbf_doa_scanner.sv
// Steering-side sweep controller for the CBF DOA chain: steps an angle table into the
// power estimator, drops settling samples, and reports the peak angle once per sweep.
module cbf_doa_scanner #(
    parameter int WORD_LENGTH_I_AND_Q = 16,
    parameter int WORD_LENGTH_POWER   = 88,
    parameter int N_ANGLES            = 181,
    parameter int ANGLE_IDX_WIDTH     = 8,
    parameter int SETTLE_COUNT        = 9
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    output logic                                         busy,
    input  logic                                         tbl_wr_en,
    input  logic [ANGLE_IDX_WIDTH-1:0]                   tbl_wr_addr,
    input  logic [8*WORD_LENGTH_I_AND_Q-1:0]             tbl_wr_data,
    output logic [WORD_LENGTH_I_AND_Q-1:0]               Is1,
    output logic [WORD_LENGTH_I_AND_Q-1:0]               Qs1,
    output logic [WORD_LENGTH_I_AND_Q-1:0]               Is2,
    output logic [WORD_LENGTH_I_AND_Q-1:0]               Qs2,
    output logic [WORD_LENGTH_I_AND_Q-1:0]               Is3,
    output logic [WORD_LENGTH_I_AND_Q-1:0]               Qs3,
    output logic [WORD_LENGTH_I_AND_Q-1:0]               Is4,
    output logic [WORD_LENGTH_I_AND_Q-1:0]               Qs4,
    input  logic [WORD_LENGTH_POWER-1:0]                 s_axis_tdata,
    input  logic                                         s_axis_tvalid,
    output logic                                         s_axis_tready,
    output logic [WORD_LENGTH_POWER+ANGLE_IDX_WIDTH-1:0] m_axis_tdata,
    output logic                                         m_axis_tvalid,
    input  logic                                         m_axis_tready
);

    localparam int IQW    = WORD_LENGTH_I_AND_Q;
    localparam int VW     = 8 * IQW;
    localparam int PW     = WORD_LENGTH_POWER;
    localparam int IW     = ANGLE_IDX_WIDTH;
    localparam int TBL_AW = (N_ANGLES > 1) ? $clog2(N_ANGLES) : 1;
    localparam int CNT_W  = (SETTLE_COUNT > 0) ? $clog2(SETTLE_COUNT + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    localparam logic [IW-1:0]    LAST_IDX  = IW'(N_ANGLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_COUNT);

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]    max_pwr;
    logic [IW-1:0]    max_idx;
    logic [VW-1:0]    steer;

    logic [VW-1:0] tbl [N_ANGLES];

    // Table RAM has no reset so its contents survive rst; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (tbl_wr_en && (32'(tbl_wr_addr) < 32'(N_ANGLES))) begin
            tbl[tbl_wr_addr[TBL_AW-1:0]] <= tbl_wr_data;
        end
    end

    // Enabled synchronous read doubles as the steering register (read-first by construction).
    always_ff @(posedge clk) begin
        if (rst) begin
            steer <= '0;
        end else if (state == S_LOAD) begin
            steer <= tbl[idx[TBL_AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            cnt     <= '0;
            max_pwr <= '0;
            max_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        max_pwr <= '0;
                        max_idx <= '0;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt   <= '0;
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (s_axis_tvalid) begin
                        if (cnt < SETTLE_LIM) begin
                            cnt <= cnt + 1'b1;
                        end else begin
                            // Strict compare keeps the lowest index on ties.
                            if (s_axis_tdata > max_pwr) begin
                                max_pwr <= s_axis_tdata;
                                max_idx <= idx;
                            end
                            if (idx == LAST_IDX) begin
                                state <= S_RESULT;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= S_LOAD;
                            end
                        end
                    end
                end
                S_RESULT: begin
                    if (m_axis_tready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy          = (state != S_IDLE);
    assign m_axis_tvalid = (state == S_RESULT);
    assign m_axis_tdata  = {max_pwr, max_idx};
    assign s_axis_tready = 1'b1;

    assign Is1 = steer[0*IQW +: IQW];
    assign Qs1 = steer[1*IQW +: IQW];
    assign Is2 = steer[2*IQW +: IQW];
    assign Qs2 = steer[3*IQW +: IQW];
    assign Is3 = steer[4*IQW +: IQW];
    assign Qs3 = steer[5*IQW +: IQW];
    assign Is4 = steer[6*IQW +: IQW];
    assign Qs4 = steer[7*IQW +: IQW];

endmodule
